// File: rtl/int_img_pkg.sv
// Shared types and geometry helpers for the integral-image frame sequencer.
package int_img_pkg;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    SETTLE   = 2'd1,
    WAIT_OUT = 2'd2,
    CAPTURE  = 2'd3
  } ctrl_state_t;

  // Default frame geometry (laptop camera); instances override per build.
  localparam int DEF_WIDTH  = 320;
  localparam int DEF_HEIGHT = 240;

  localparam int ROW_W = $clog2(DEF_HEIGHT);
  localparam int COL_W = $clog2(DEF_WIDTH);

  typedef logic [ROW_W-1:0] row_idx_t;
  typedef logic [COL_W-1:0] col_idx_t;

  // Index width for a dimension; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_img_frame_ctrl_raster_counter.sv
// Raster row/column tracker for the frame-buffer write port, with SOF restart.
module raster_counter
  import int_img_pkg::*;
#(
  parameter int WIDTH_LIMIT  = DEF_WIDTH,
  parameter int HEIGHT_LIMIT = DEF_HEIGHT
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          advance,
  input  logic                          sof,
  output logic [idx_w(HEIGHT_LIMIT)-1:0] cur_row,
  output logic [idx_w(WIDTH_LIMIT)-1:0]  cur_col,
  output logic                          sof_restart,
  output logic                          last
);

  localparam int RW = idx_w(HEIGHT_LIMIT);
  localparam int CW = idx_w(WIDTH_LIMIT);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_LIMIT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH_LIMIT - 1);

  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          at_origin;
  logic          col_end;

  // An SOF pixel is always placed at the origin, wherever the counters were.
  always_comb begin
    at_origin   = (row_q == '0) && (col_q == '0);
    sof_restart = sof && !at_origin;
    cur_row     = sof ? '0 : row_q;
    cur_col     = sof ? '0 : col_q;
    col_end     = (cur_col == COL_LAST);
    last        = col_end && (cur_row == ROW_LAST);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (advance) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= last ? '0 : cur_row + RW'(1);
      end else begin
        col_q <= cur_col + CW'(1);
        row_q <= cur_row;
      end
    end
  end

endmodule

// File: rtl/int_img_frame_ctrl.sv
// Frame sequencer for the integral-image datapath: loads the frame buffer,
// waits out the multicycle settle budget, then strobes the result registers.
//
// state    | meaning
// LOAD     | accepting raster pixels into the frame buffer
// SETTLE   | integral array settling after the last write
// WAIT_OUT | result regs still held by scanner; capture fires on release
// CAPTURE  | result regs load the new integral image
module int_img_frame_ctrl
  import int_img_pkg::*;
#(
  parameter int WIDTH_LIMIT   = DEF_WIDTH,
  parameter int HEIGHT_LIMIT  = DEF_HEIGHT,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [7:0]                     pixel_in,
  input  logic                           pixel_valid,
  input  logic                           pixel_sof,
  output logic                           pixel_ready,
  output logic                           pix_wr_en,
  output logic [idx_w(HEIGHT_LIMIT)-1:0] pix_wr_row,
  output logic [idx_w(WIDTH_LIMIT)-1:0]  pix_wr_col,
  output logic [7:0]                     pix_wr_data,
  output logic                           calc_capture,
  output logic                           int_valid,
  input  logic                           int_release,
  output logic [15:0]                    frame_count,
  output logic                           sof_error
);

  localparam int RW   = idx_w(HEIGHT_LIMIT);
  localparam int CW   = idx_w(WIDTH_LIMIT);
  localparam int SC_W = idx_w(SETTLE_CYCLES);

  ctrl_state_t   state_q, state_d;
  logic [SC_W-1:0] settle_q;
  logic          accept;
  logic          release_ok;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;
  logic          sof_restart;
  logic          frame_last;

  logic          wr_en_q;
  logic [RW-1:0] wr_row_q;
  logic [CW-1:0] wr_col_q;
  logic [7:0]    wr_data_q;
  logic          int_valid_q;
  logic [15:0]   frame_cnt_q;
  logic          sof_error_q;

  assign accept     = pixel_valid && pixel_ready;
  assign release_ok = !int_valid_q || int_release;

  raster_counter #(
    .WIDTH_LIMIT  (WIDTH_LIMIT),
    .HEIGHT_LIMIT (HEIGHT_LIMIT)
  ) u_raster (
    .clock       (clock),
    .reset_n     (reset_n),
    .advance     (accept),
    .sof         (pixel_sof),
    .cur_row     (cur_row),
    .cur_col     (cur_col),
    .sof_restart (sof_restart),
    .last        (frame_last)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= LOAD;
    else          state_q <= state_d;
  end

  // WAIT_OUT captures in the release cycle itself so int_valid never drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:     if (accept && frame_last) state_d = SETTLE;
      SETTLE:   if (settle_q == '0) state_d = release_ok ? CAPTURE : WAIT_OUT;
      WAIT_OUT: if (release_ok) state_d = LOAD;
      CAPTURE:  state_d = LOAD;
      default:  state_d = LOAD;
    endcase
  end

  always_comb begin
    pixel_ready  = (state_q == LOAD);
    calc_capture = (state_q == CAPTURE) || ((state_q == WAIT_OUT) && release_ok);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      settle_q <= '0;
    end else if ((state_q == LOAD) && accept && frame_last) begin
      settle_q <= SC_W'(SETTLE_CYCLES - 1);
    end else if ((state_q == SETTLE) && (settle_q != '0)) begin
      settle_q <= settle_q - SC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_row_q  <= cur_row;
        wr_col_q  <= cur_col;
        wr_data_q <= pixel_in;
      end
    end
  end

  // A capture in the same cycle as a release keeps the image valid.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      int_valid_q <= 1'b0;
      frame_cnt_q <= '0;
      sof_error_q <= 1'b0;
    end else begin
      if (calc_capture)     int_valid_q <= 1'b1;
      else if (int_release) int_valid_q <= 1'b0;
      if (calc_capture) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (accept && sof_restart) sof_error_q <= 1'b1;
    end
  end

  assign pix_wr_en   = wr_en_q;
  assign pix_wr_row  = wr_row_q;
  assign pix_wr_col  = wr_col_q;
  assign pix_wr_data = wr_data_q;
  assign int_valid   = int_valid_q;
  assign frame_count = frame_cnt_q;
  assign sof_error   = sof_error_q;

endmodule

// File: tb/tb_int_img_frame_ctrl.sv
// Directed bench for int_img_frame_ctrl on a 4x3 frame (settle 4 and settle 1).
module tb_int_img_frame_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pixel_in = '0;
  logic       pixel_valid = 1'b0;
  logic       pixel_sof = 1'b0;
  logic       int_release = 1'b0;

  logic        pixel_ready, pix_wr_en, calc_capture, int_valid, sof_error;
  logic [1:0]  pix_wr_row, pix_wr_col;
  logic [7:0]  pix_wr_data;
  logic [15:0] frame_count;

  logic        pixel_ready_1, pix_wr_en_1, calc_capture_1, int_valid_1, sof_error_1;
  logic [1:0]  pix_wr_row_1, pix_wr_col_1;
  logic [7:0]  pix_wr_data_1;
  logic [15:0] frame_count_1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;
  int iv_rise = -1;
  logic iv_prev = 1'b0;
  logic [11:0] wr_q[$];
  int cap_q[$];
  int cap1_q[$];

  int_img_frame_ctrl #(.WIDTH_LIMIT(4), .HEIGHT_LIMIT(3), .SETTLE_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .pixel_sof(pixel_sof), .pixel_ready(pixel_ready), .pix_wr_en(pix_wr_en),
    .pix_wr_row(pix_wr_row), .pix_wr_col(pix_wr_col), .pix_wr_data(pix_wr_data),
    .calc_capture(calc_capture), .int_valid(int_valid), .int_release(int_release),
    .frame_count(frame_count), .sof_error(sof_error)
  );

  int_img_frame_ctrl #(.WIDTH_LIMIT(4), .HEIGHT_LIMIT(3), .SETTLE_CYCLES(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .pixel_sof(pixel_sof), .pixel_ready(pixel_ready_1), .pix_wr_en(pix_wr_en_1),
    .pix_wr_row(pix_wr_row_1), .pix_wr_col(pix_wr_col_1), .pix_wr_data(pix_wr_data_1),
    .calc_capture(calc_capture_1), .int_valid(int_valid_1), .int_release(int_release),
    .frame_count(frame_count_1), .sof_error(sof_error_1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (pix_wr_en) wr_q.push_back({pix_wr_row, pix_wr_col, pix_wr_data});
    if (calc_capture) cap_q.push_back(cyc);
    if (calc_capture_1) cap1_q.push_back(cyc);
    if (pixel_valid && pixel_ready) last_acc = cyc;
    if (int_valid && !iv_prev) iv_rise = cyc;
    iv_prev = int_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input int n, input int sof_at, input bit gapped);
    int guard;
    for (int i = 0; i < n; i++) begin
      if (gapped) begin
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
        step(1);
      end
      pixel_in    = 8'(i);
      pixel_valid = 1'b1;
      pixel_sof   = (i == sof_at);
      guard = 0;
      while (!pixel_ready && guard < 200) begin
        step(1);
        guard++;
      end
      if (guard >= 200) chk("ready_timeout", 32'(pixel_ready), 32'd1);
      step(1);
    end
    pixel_valid = 1'b0;
    pixel_sof   = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n, input int sof_at);
    int k;
    chk({tag, "_wr_count"}, 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      k = (sof_at >= 0 && i >= sof_at) ? i - sof_at : i;
      chk({tag, "_wr"}, 32'(wr_q[i]), 32'({2'(k / 4), 2'(k % 4), 8'(i)}));
    end
  endtask

  initial begin
    int r;
    // reset
    step(2);
    chk("rst_int_valid", 32'(int_valid), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_capture", 32'(calc_capture), 32'd0);
    chk("rst_wr_en", 32'(pix_wr_en), 32'd0);
    chk("rst_sof_error", 32'(sof_error), 32'd0);
    reset_n = 1'b1;
    step(1);
    chk("rst_ready", 32'(pixel_ready), 32'd1);

    // 1: single frame, immediate release
    wr_q.delete(); cap_q.delete();
    int_release = 1'b1;
    send_frame(12, -1, 1'b0);
    step(10);
    check_writes("t1", 12, -1);
    chk("t1_cap_count", 32'(cap_q.size()), 32'd1);
    if (cap_q.size() > 0) chk("t1_cap_lat", 32'(cap_q[0] - last_acc), 32'd5);
    chk("t1_iv_lat", 32'(iv_rise - last_acc), 32'd6);
    chk("t1_frame_count", 32'(frame_count), 32'd1);

    // 2: back-to-back frames, scanner holds the first result
    int_release = 1'b0;
    cap_q.delete();
    send_frame(12, -1, 1'b0);
    send_frame(12, -1, 1'b0);
    step(15);
    chk("t2_blocked_ready", 32'(pixel_ready), 32'd0);
    chk("t2_blocked_caps", 32'(cap_q.size()), 32'd1);
    chk("t2_blocked_count", 32'(frame_count), 32'd2);
    int_release = 1'b1;
    r = cyc;
    step(1);
    int_release = 1'b0;
    chk("t2_rel_caps", 32'(cap_q.size()), 32'd2);
    if (cap_q.size() > 1) chk("t2_rel_cap_cyc", 32'(cap_q[1]), 32'(r));
    chk("t2_iv_hold", 32'(int_valid), 32'd1);
    step(1);
    chk("t2_iv_hold2", 32'(int_valid), 32'd1);
    chk("t2_frame_count", 32'(frame_count), 32'd3);
    chk("t2_ready_again", 32'(pixel_ready), 32'd1);

    // 3: gapped stream
    int_release = 1'b1;
    wr_q.delete(); cap_q.delete();
    send_frame(12, -1, 1'b1);
    step(10);
    check_writes("t3", 12, -1);
    if (cap_q.size() > 0) chk("t3_cap_lat", 32'(cap_q[0] - last_acc), 32'd5);
    chk("t3_frame_count", 32'(frame_count), 32'd4);

    // 4: SOF on the 6th pixel restarts the raster
    wr_q.delete(); cap_q.delete();
    send_frame(17, 5, 1'b0);
    step(10);
    check_writes("t4", 17, 5);
    chk("t4_sof_error", 32'(sof_error), 32'd1);
    chk("t4_cap_count", 32'(cap_q.size()), 32'd1);
    if (cap_q.size() > 0) chk("t4_cap_lat", 32'(cap_q[0] - last_acc), 32'd5);
    chk("t4_frame_count", 32'(frame_count), 32'd5);

    // 5: reset during SETTLE
    cap_q.delete();
    send_frame(12, -1, 1'b0);
    step(1);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    chk("t5_ready", 32'(pixel_ready), 32'd1);
    chk("t5_int_valid", 32'(int_valid), 32'd0);
    chk("t5_frame_count", 32'(frame_count), 32'd0);
    chk("t5_sof_error", 32'(sof_error), 32'd0);
    step(10);
    chk("t5_no_cap", 32'(cap_q.size()), 32'd0);
    wr_q.delete();
    send_frame(12, -1, 1'b0);
    step(10);
    check_writes("t5", 12, -1);
    chk("t5_cap_count", 32'(cap_q.size()), 32'd1);
    chk("t5_frame_count2", 32'(frame_count), 32'd1);

    // 6: settle of one cycle and frame_count wrap on the second instance
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    dut1.frame_cnt_q = 16'hFFFF;
    step(1);
    chk("t6_preset", 32'(frame_count_1), 32'h0000FFFF);
    cap1_q.delete();
    send_frame(12, -1, 1'b0);
    step(6);
    chk("t6_cap_count", 32'(cap1_q.size()), 32'd1);
    if (cap1_q.size() > 0) chk("t6_cap_lat", 32'(cap1_q[0] - last_acc), 32'd2);
    chk("t6_wrap", 32'(frame_count_1), 32'd0);
    chk("t6_dut0_count", 32'(frame_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
